// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences one kernel-load phase and one execute phase of the
// weight-stationary systolic MAC array. It drives the row-skewed instruction
// bus, the L0 read strobe and the per-column output-valid strobes for the OFIFO.
module mac_array_ctrl #(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int len_bw = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [len_bw-1:0]   cfg_len,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic                l0_rd,
   output logic [2*row-1:0]    inst_w,
   output logic [col-1:0]      col_valid
);

   // The counter must hold both the largest vector count and the drain length.
   localparam int DRAIN_W = $clog2(row + col + 2);
   localparam int CNT_W   = (len_bw > DRAIN_W) ? len_bw : DRAIN_W;
   localparam int DLY_W   = row + col;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_GAP   = 3'd2,
      ST_EXEC  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [1:0] INST_NOP  = 2'b00;
   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [len_bw-1:0]   len_q, len_d;
   logic [1:0]          base_s;
   logic                exec_s;
   logic [2*row-1:0]    inst_q;
   logic [DLY_W-1:0]    dly_q;

   // Next-state logic: counter-driven phase sequencing and base instruction.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      base_s  = INST_NOP;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d   = cfg_len;
               cnt_d   = CNT_W'(col - 1);
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            base_s = INST_LOAD;
            if (cnt_q == CNT_W'(0)) begin
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            // One idle slot so every tile drops load_ready before execute.
            if (len_q == len_bw'(0)) begin
               cnt_d   = CNT_W'(row + col);
               state_d = ST_DRAIN;
            end else begin
               cnt_d   = CNT_W'(len_q) - CNT_W'(1);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            base_s = INST_EXEC;
            if (cnt_q == CNT_W'(0)) begin
               cnt_d   = CNT_W'(row + col);
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            // Wait for the skewed instructions and psums to leave the array.
            if (cnt_q == CNT_W'(0)) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_W'(0);
            len_d   = len_bw'(0);
         end
      endcase
   end

   // Status decode from the state register; l0_rd follows the fetch phases.
   always_comb begin
      ready  = (state_q == ST_IDLE);
      busy   = (state_q != ST_IDLE);
      done   = (state_q == ST_DONE);
      l0_rd  = (state_q == ST_LOAD) || (state_q == ST_EXEC);
      exec_s = (base_s == INST_EXEC);
   end

   // FSM, counter and latched job length.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_W'(0);
         len_q   <= len_bw'(0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // Row-skew shift line: row 0 takes the base instruction, row r takes row r-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_q <= '0;
      end else begin
         inst_q <= {inst_q[2*row-3:0], base_s};
      end
   end

   // Exec-flag delay line; tap row+c gives the valid strobe of column c.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dly_q <= '0;
      end else begin
         dly_q <= {dly_q[DLY_W-2:0], exec_s};
      end
   end

   assign inst_w    = inst_q;
   assign col_valid = dly_q[DLY_W-1:row];

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: randomized bench for mac_array_ctrl. A job-level model
// expands each accepted job into its per-cycle base-instruction schedule and
// derives every output from the time history of that schedule.
module tb_mac_array_ctrl;

   localparam int ROW    = 8;
   localparam int COL    = 8;
   localparam int LEN_BW = 8;
   localparam int HMAX   = 8192;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [LEN_BW-1:0]   cfg_len;
   logic                ready, busy, done, l0_rd;
   logic [2*ROW-1:0]    inst_w;
   logic [COL-1:0]      col_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: cur = -1 idle, 0 nop, 1 load, 2 exec, 3 done slot.
   int sched[$];
   int cur        = -1;
   int cyc        = 0;
   int valid_from = 0;
   int hist[HMAX];
   int busy_cnt   = 0;
   int done_cnt   = 0;

   mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LEN_BW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_len   (cfg_len),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .l0_rd     (l0_rd),
      .inst_w    (inst_w),
      .col_valid (col_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int h(input int i);
      if (i < 0 || i < valid_from) return 0;
      return hist[i];
   endfunction

   // Model update for one rising edge.
   task automatic model_edge();
      if (reset) begin
         sched.delete();
         cur = -1;
      end else begin
         if (cur == -1 && start) begin
            for (int i = 0; i < COL; i++) sched.push_back(1);
            sched.push_back(0);
            for (int i = 0; i < int'(cfg_len); i++) sched.push_back(2);
            for (int i = 0; i < ROW + COL + 1; i++) sched.push_back(0);
            sched.push_back(3);
         end
         if (sched.size() > 0) cur = sched.pop_front();
         else cur = -1;
      end
      cyc++;
      if (cyc >= HMAX) begin
         $display("FAIL hist_overflow cyc=%0d got=%0d exp=%0d", cyc, cyc, HMAX - 1);
         $fatal(1, "history overflow");
      end
      hist[cyc] = (cur == 1 || cur == 2) ? cur : 0;
      if (reset) valid_from = cyc;
   endtask

   task automatic compare_all();
      logic [2*ROW-1:0] e_inst;
      logic [COL-1:0]   e_cv;
      e_inst = '0;
      e_cv   = '0;
      for (int r = 0; r < ROW; r++) e_inst[2*r +: 2] = 2'(h(cyc - r - 1));
      for (int c = 0; c < COL; c++) e_cv[c] = (h(cyc - ROW - 1 - c) == 2);
      check("ready",     ready,     (cur == -1));
      check("busy",      busy,      (cur != -1));
      check("done",      done,      (cur == 3));
      check("l0_rd",     l0_rd,     (cur == 1 || cur == 2));
      check("inst_w",    inst_w,    e_inst);
      check("col_valid", col_valid, e_cv);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
   endtask

   // One start pulse, then run until the model is idle again.
   task automatic run_job(input int len, input int max_cyc);
      cfg_len  = LEN_BW'(len);
      start    = 1'b1;
      busy_cnt = 0;
      done_cnt = 0;
      step();
      start = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (cur == -1) break;
         cfg_len = LEN_BW'($urandom);
         step();
      end
      check("job_len",  busy_cnt, 2 * COL + len + ROW + 3);
      check("done_cnt", done_cnt, 1);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      cfg_len = '0;
      step();
      step();
      reset = 1'b0;
      repeat (3) step();

      run_job(3, 100);
      repeat (2) step();
      run_job(0, 100);
      repeat (2) step();

      // Start held high: jobs accepted only from IDLE.
      cfg_len = LEN_BW'(2);
      start   = 1'b1;
      repeat (90) step();
      start = 1'b0;
      repeat (40) step();

      // Random start pulses and lengths, cfg_len churning every cycle.
      repeat (500) begin
         start   = ($urandom_range(0, 3) == 0);
         cfg_len = LEN_BW'($urandom_range(0, 12));
         step();
      end
      start = 1'b0;
      repeat (60) step();

      run_job(255, 400);
      repeat (2) step();

      // Asynchronous reset in the middle of EXEC.
      cfg_len = LEN_BW'(40);
      start   = 1'b1;
      step();
      start = 1'b0;
      repeat (14) step();
      #2 reset = 1'b1;
      #1;
      check("arst_ready",     ready,     1);
      check("arst_busy",      busy,      0);
      check("arst_done",      done,      0);
      check("arst_l0_rd",     l0_rd,     0);
      check("arst_inst_w",    inst_w,    0);
      check("arst_col_valid", col_valid, 0);
      step();
      reset = 1'b0;
      repeat (2) step();
      run_job(5, 100);
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
